multicycle_control: RTL
=======================

Name: multicycle_control

Overview:
- Moore-style control FSM for the multicycle datapath. It sequences the instruction register, PC, memory interface, register file and ALU muxes through fetch/decode/execute/memory/writeback.
- It reads the opcode from the latched instruction, ir[31:26], and emits one set of control strobes per cycle.
- It stalls on a memory-ready handshake and flags illegal opcodes.

Parameters:
- STATE_W, 4, width of the exported state vector.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high
- opcode  input  6  instruction opcode from the IR output, bits 31:26
- zero  input  1  ALU zero flag; used only for branch qualification by the datapath
- mem_ready  input  1  memory access complete this cycle
- ir_write  output  1  load the IR (drives the instruction register's IRWrite)
- pc_write  output  1  unconditional PC load
- pc_write_cond  output  1  PC load if zero
- i_or_d  output  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read  output  1  memory read request
- mem_write  output  1  memory write request
- mem_to_reg  output  1  register write data: 0 = ALUOut, 1 = MDR
- reg_dst  output  1  destination register: 0 = rt, 1 = rd
- reg_write  output  1  register file write enable
- alu_src_a  output  1  0 = PC, 1 = rs
- alu_src_b  output  2  0 = rt, 1 = const 4, 2 = sign-extended imm, 3 = sign-extended imm shifted left 2
- alu_op  output  2  0 = add, 1 = sub, 2 = funct, 3 = reserved
- pc_source  output  2  0 = ALU result, 1 = ALUOut, 2 = jump target
- illegal_op  output  1  one-cycle pulse on an undefined opcode
- state  output  STATE_W  current state, for debug

Behaviour:
- Reset:
  - reset is synchronous, active-high; clock is clk.
  - While reset is high, every control output is 0 and illegal_op is 0.
  - The state register loads FETCH (0) on the clock edge.
  - A reset mid-instruction abandons the instruction: the next state is FETCH with no partial writes.
- All outputs are decoded from the state register plus mem_ready. Anything not listed for a state is 0.
- State encodings and outputs:
  - FETCH (0): mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=1, alu_op=0, pc_source=0.
    - ir_write and pc_write are asserted only when mem_ready=1.
    - mem_ready=0: hold in FETCH, mem_read stays high.
    - mem_ready=1: go to DECODE.
  - DECODE (1): alu_src_a=0, alu_src_b=3, alu_op=0 (branch target precompute). Next state by opcode:
    - 000000 -> RTYPE_EX
    - 100011 or 101011 -> MEMADDR
    - 000100 -> BRANCH
    - 000010 -> JUMP
    - 001000 -> ADDI_EX
    - any other -> FETCH, with illegal_op=1 for this cycle only.
  - MEMADDR (2): alu_src_a=1, alu_src_b=2, alu_op=0. Next: MEMRD if opcode=100011, else MEMWR.
  - MEMRD (3): mem_read=1, i_or_d=1. Hold until mem_ready=1, then go to MEMWB.
  - MEMWB (4): reg_write=1, mem_to_reg=1, reg_dst=0. Next: FETCH.
  - MEMWR (5): mem_write=1, i_or_d=1. Hold until mem_ready=1, then go to FETCH.
  - RTYPE_EX (6): alu_src_a=1, alu_src_b=0, alu_op=2. Next: RTYPE_WB.
  - RTYPE_WB (7): reg_write=1, reg_dst=1, mem_to_reg=0. Next: FETCH.
  - BRANCH (8): alu_src_a=1, alu_src_b=0, alu_op=1, pc_write_cond=1, pc_source=1. Next: FETCH.
  - JUMP (9): pc_write=1, pc_source=2. Next: FETCH.
  - ADDI_EX (10): alu_src_a=1, alu_src_b=2, alu_op=0. Next: ADDI_WB.
  - ADDI_WB (11): reg_write=1, reg_dst=0, mem_to_reg=0. Next: FETCH.
  - Encodings 12-15 are unreachable; if entered, go to FETCH with all outputs 0.
- Latency with mem_ready tied high:
  - R-type, addi and lw: 4 or 5 cycles; sw: 4; beq and j: 3.
  - Each wait cycle adds 1.
- mem_ready is sampled only in FETCH, MEMRD and MEMWR and is ignored elsewhere.
- The opcode is sampled only in DECODE and MEMADDR. It must be stable there because the IR holds it.
- pc_write and pc_write_cond are never both 1 in the same cycle.

Optional Feature:
- Macro PERF_COUNT_EN.
- Defined:
  - Adds output instr_count[31:0] and output stall_count[31:0], both cleared by reset.
  - instr_count increments on every FETCH cycle with mem_ready=1.
  - stall_count increments on every FETCH, MEMRD or MEMWR cycle with mem_ready=0.
  - Both wrap from 0xFFFFFFFF to 0.
- Undefined: both ports and counters are absent; FSM behaviour is identical.

Test Plan:
- Reset held 3 cycles, then released, mem_ready=1 -> all strobes 0 during reset; state=0 in the first post-reset cycle with mem_read=1, ir_write=1, pc_write=1.
- opcode=000000, mem_ready=1 -> state sequence 0,1,6,7,0; reg_write=1 and reg_dst=1 only in state 7; alu_op=2 in state 6.
- opcode=100011, mem_ready low for 2 cycles in MEMRD -> sequence 0,1,2,3,3,3,4,0; mem_read held for all three state-3 cycles; mem_to_reg=1 in state 4.
- opcode=101011 then opcode=000100 -> sw: 0,1,2,5,0 with mem_write=1 and i_or_d=1 in state 5; beq: 0,1,8,0 with pc_write_cond=1 and alu_op=1.
- opcode=111111 -> illegal_op=1 for exactly one cycle in state 1; next state 0; no reg_write or mem_write asserted.
- Reset asserted while in MEMWR with mem_ready=0 -> mem_write drops that cycle; state=0 after the edge; with PERF_COUNT_EN, instr_count=0 and stall_count=0.

Source files
------------

// File: rtl/multicycle_control_if.sv
// rtl/multicycle_control_if.sv - control/datapath signal bundle for multicycle_control
//
// Purpose: carries the opcode/status inputs and the per-cycle control strobes
// between the multicycle control FSM and the datapath it sequences.
// Modports:
//    master - the control FSM: reads opcode, zero, mem_ready; drives strobes, state
//    slave  - the datapath: drives opcode, zero, mem_ready; reads strobes, state
// Signals:
//    opcode[5:0]   IR bits 31:26
//    zero          ALU zero flag (branch qualification happens in the datapath)
//    mem_ready     memory access completes this cycle
//    ir_write, pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
//    mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b[1:0], alu_op[1:0],
//    pc_source[1:0], illegal_op, state[STATE_W-1:0]

interface multicycle_control_if #(
   parameter int STATE_W = 4
);
   logic [5:0]         opcode;
   logic               zero;
   logic               mem_ready;
   logic               ir_write;
   logic               pc_write;
   logic               pc_write_cond;
   logic               i_or_d;
   logic               mem_read;
   logic               mem_write;
   logic               mem_to_reg;
   logic               reg_dst;
   logic               reg_write;
   logic               alu_src_a;
   logic [1:0]         alu_src_b;
   logic [1:0]         alu_op;
   logic [1:0]         pc_source;
   logic               illegal_op;
   logic [STATE_W-1:0] state;

   modport master (
      input  opcode, zero, mem_ready,
      output ir_write, pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
             mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
             pc_source, illegal_op, state
   );

   modport slave (
      output opcode, zero, mem_ready,
      input  ir_write, pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
             mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
             pc_source, illegal_op, state
   );
endinterface

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - Moore control FSM for the multicycle datapath
//
// Purpose: sequences fetch/decode/execute/memory/writeback for the multicycle
// datapath, emitting one set of control strobes per cycle decoded from the
// state register (plus mem_ready in the memory-wait states). Stalls on
// mem_ready and pulses illegal_op for one cycle on an undefined opcode.
// Ports:
//    clk          system clock
//    reset        synchronous, active-high; forces all strobes low this cycle
//    bus          multicycle_control_if.master (opcode/zero/mem_ready in,
//                 control strobes and debug state out)
//    instr_count  [31:0] fetched-instruction count   (PERF_COUNT_EN only)
//    stall_count  [31:0] memory-wait cycle count     (PERF_COUNT_EN only)
// Build option: define PERF_COUNT_EN to add the two performance counters.

module multicycle_control #(
   parameter int STATE_W = 4
) (
   input  logic                clk,
   input  logic                reset,
   multicycle_control_if.master bus
`ifdef PERF_COUNT_EN
   ,
   output logic [31:0]         instr_count,
   output logic [31:0]         stall_count
`endif
);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADDR  = 4'd2,
      MEMRD    = 4'd3,
      MEMWB    = 4'd4,
      MEMWR    = 4'd5,
      RTYPE_EX = 4'd6,
      RTYPE_WB = 4'd7,
      BRANCH   = 4'd8,
      JUMP     = 4'd9,
      ADDI_EX  = 4'd10,
      ADDI_WB  = 4'd11
   } stateT;

   stateT stateReg;
   stateT nextState;

   // The zero flag qualifies branches inside the datapath, not here.
   logic unusedZero;
   assign unusedZero = bus.zero;

   always_ff @(posedge clk) begin
      if (reset) stateReg <= FETCH;
      else       stateReg <= nextState;
   end

   always_comb begin
      nextState         = FETCH;
      bus.ir_write      = 1'b0;
      bus.pc_write      = 1'b0;
      bus.pc_write_cond = 1'b0;
      bus.i_or_d        = 1'b0;
      bus.mem_read      = 1'b0;
      bus.mem_write     = 1'b0;
      bus.mem_to_reg    = 1'b0;
      bus.reg_dst       = 1'b0;
      bus.reg_write     = 1'b0;
      bus.alu_src_a     = 1'b0;
      bus.alu_src_b     = 2'd0;
      bus.alu_op        = 2'd0;
      bus.pc_source     = 2'd0;
      bus.illegal_op    = 1'b0;
      // Gating on reset makes a mid-instruction reset drop every write strobe
      // in the same cycle, so an abandoned instruction leaves no partial writes.
      if (!reset) begin
         case (stateReg)
            FETCH: begin
               bus.mem_read  = 1'b1;
               bus.alu_src_b = 2'd1;
               if (bus.mem_ready) begin
                  bus.ir_write = 1'b1;
                  bus.pc_write = 1'b1;
                  nextState    = DECODE;
               end else begin
                  nextState    = FETCH;
               end
            end
            DECODE: begin
               bus.alu_src_b = 2'd3;   // branch target precompute
               case (bus.opcode)
                  OP_RTYPE:     nextState = RTYPE_EX;
                  OP_LW, OP_SW: nextState = MEMADDR;
                  OP_BEQ:       nextState = BRANCH;
                  OP_J:         nextState = JUMP;
                  OP_ADDI:      nextState = ADDI_EX;
                  default: begin
                     nextState      = FETCH;
                     bus.illegal_op = 1'b1;
                  end
               endcase
            end
            MEMADDR: begin
               bus.alu_src_a = 1'b1;
               bus.alu_src_b = 2'd2;
               nextState     = (bus.opcode == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
               bus.mem_read = 1'b1;
               bus.i_or_d   = 1'b1;
               nextState    = bus.mem_ready ? MEMWB : MEMRD;
            end
            MEMWB: begin
               bus.reg_write  = 1'b1;
               bus.mem_to_reg = 1'b1;
            end
            MEMWR: begin
               bus.mem_write = 1'b1;
               bus.i_or_d    = 1'b1;
               nextState     = bus.mem_ready ? FETCH : MEMWR;
            end
            RTYPE_EX: begin
               bus.alu_src_a = 1'b1;
               bus.alu_op    = 2'd2;
               nextState     = RTYPE_WB;
            end
            RTYPE_WB: begin
               bus.reg_write = 1'b1;
               bus.reg_dst   = 1'b1;
            end
            BRANCH: begin
               bus.alu_src_a     = 1'b1;
               bus.alu_op        = 2'd1;
               bus.pc_write_cond = 1'b1;
               bus.pc_source     = 2'd1;
            end
            JUMP: begin
               bus.pc_write  = 1'b1;
               bus.pc_source = 2'd2;
            end
            ADDI_EX: begin
               bus.alu_src_a = 1'b1;
               bus.alu_src_b = 2'd2;
               nextState     = ADDI_WB;
            end
            ADDI_WB: begin
               bus.reg_write = 1'b1;
            end
            default: ;   // encodings 12-15: all strobes low, recover to FETCH
         endcase
      end
   end

   assign bus.state = STATE_W'(stateReg);

`ifdef PERF_COUNT_EN
   logic memWaitState;
   assign memWaitState = (stateReg == FETCH) || (stateReg == MEMRD) || (stateReg == MEMWR);

   always_ff @(posedge clk) begin
      if (reset) begin
         instr_count <= 32'd0;
         stall_count <= 32'd0;
      end else begin
         if (stateReg == FETCH && bus.mem_ready) instr_count <= instr_count + 32'd1;
         if (memWaitState && !bus.mem_ready)     stall_count <= stall_count + 32'd1;
      end
   end
`endif

endmodule
